// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side issues conversion requests; the slave side is the converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  sgn;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;
    logic [DIGITS-1:0]     digit_mask;

    modport master (
        output start, sgn, bin_in,
        input  busy, done, bcd_out, neg, digit_mask
    );

    modport slave (
        input  start, sgn, bin_in,
        output busy, done, bcd_out, neg, digit_mask
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input, sign flag and leading-digit blanking mask.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);

    // Number of decimal digits needed to hold 2^bw - 1.
    function automatic int unsigned digits_needed(input int unsigned bw);
        logic [63:0]  v;
        int unsigned  n;
        v = (bw >= 64) ? '1 : ((64'd1 << bw) - 64'd1);
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    localparam int unsigned NEED  = digits_needed(BIN_W);
    localparam int unsigned CNT_W = $clog2(BIN_W);

    if (BIN_W < 2) begin : g_bin_w_check
        $error("bin_to_bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < NEED) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small to hold 2^BIN_W-1");
    end

    // FIN is folded into the last CONV edge, which returns straight to IDLE.
    typedef enum logic {IDLE, CONV} state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_q;
    logic [4*DIGITS-1:0]  acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sign_q;
    logic                 done_q;
    logic [4*DIGITS-1:0]  bcd_out_q;
    logic                 neg_q;
    logic [DIGITS-1:0]    mask_q;

    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  acc_nx;
    logic [BIN_W-1:0]     bin_nx;
    logic [DIGITS-1:0]    mask_nx;
    logic [BIN_W-1:0]     mag;
    logic                 in_neg;
    logic                 last;

    assign last   = (cnt_q == CNT_W'(BIN_W - 1));
    assign in_neg = bus.sgn & bus.bin_in[BIN_W-1];

    // Operand magnitude; the most negative value maps onto 2^(BIN_W-1) unchanged.
    always_comb begin
        mag = bus.bin_in;
        if (in_neg) begin
            mag = (~bus.bin_in) + {{(BIN_W-1){1'b0}}, 1'b1};
        end
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left.
    always_comb begin
        adj = acc_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_nx = {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        bin_nx = {bin_q[BIN_W-2:0], 1'b0};
    end

    // Blanking mask: a digit is shown if it or any more significant digit is nonzero.
    always_comb begin
        mask_nx = '0;
        mask_nx[DIGITS-1] = |acc_nx[4*(DIGITS-1) +: 4];
        for (int unsigned k = 1; k < DIGITS; k++) begin
            mask_nx[DIGITS-1-k] = mask_nx[DIGITS-k] | (|acc_nx[4*(DIGITS-1-k) +: 4]);
        end
        mask_nx[0] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (last)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Working register, iteration counter and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            neg_q     <= 1'b0;
            mask_q    <= DIGITS'(1);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q  <= mag;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        sign_q <= in_neg;
                    end
                end
                CONV: begin
                    bin_q <= bin_nx;
                    acc_q <= acc_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        bcd_out_q <= acc_nx;
                        neg_q     <= sign_q;
                        mask_q    <= mask_nx;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        bus.busy       = (state_q == CONV);
        bus.done       = done_q;
        bus.bcd_out    = bcd_out_q;
        bus.neg        = neg_q;
        bus.digit_mask = mask_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 12-bit/4-digit and a 20-bit/7-digit instance,
// each shadowed by a cycle-level arithmetic model compared on every falling edge.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int vectors = 0;
    int fails   = 0;

    bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) ifa ();
    bin_to_bcd_seq_if #(.BIN_W(20), .DIGITS(7)) ifb ();

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(7)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic [31:0] left;
        logic [63:0] mag;
        logic        pend;
        logic        done;
        logic [63:0] bcd;
        logic        neg;
        logic [63:0] mask;
    } mstate_t;

    mstate_t ma, mb;

    function automatic logic [63:0] to_bcd(input logic [63:0] v, input int unsigned d);
        logic [63:0] r = '0;
        for (int unsigned i = 0; i < d; i++) begin
            r = r | ((v % 64'd10) << (4 * i));
            v = v / 64'd10;
        end
        return r;
    endfunction

    function automatic logic [63:0] dmask(input logic [63:0] v, input int unsigned d);
        logic [63:0] r = 64'd1;
        logic [63:0] p = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            if (v >= p) r = r | (64'd1 << i);
            p = p * 64'd10;
        end
        return r;
    endfunction

    function automatic mstate_t mreset();
        mstate_t s = '0;
        s.mask = 64'd1;
        return s;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic st, input logic sg,
                                      input logic [63:0] v, input int unsigned w,
                                      input int unsigned d);
        mstate_t n = s;
        logic    isneg;
        n.done = 1'b0;
        if (s.busy) begin
            n.left = s.left - 32'd1;
            if (n.left == 32'd0) begin
                n.busy = 1'b0;
                n.done = 1'b1;
                n.bcd  = to_bcd(s.mag, d);
                n.neg  = s.pend;
                n.mask = dmask(s.mag, d);
            end
        end else if (st) begin
            isneg  = sg && v[w-1];
            n.mag  = isneg ? ((64'd1 << w) - v) : v;
            n.pend = isneg;
            n.busy = 1'b1;
            n.left = w;
        end
        return n;
    endfunction

    // Reference models advance on the same edges as the DUTs.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) ma <= mreset();
        else       ma <= mstep(ma, ifa.start, ifa.sgn, 64'(ifa.bin_in), 12, 4);
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) mb <= mreset();
        else       mb <= mstep(mb, ifb.start, ifb.sgn, 64'(ifb.bin_in), 20, 7);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against their models.
    always @(negedge clk) begin
        chk("A.busy", 64'(ifa.busy), 64'(ma.busy));
        chk("A.done", 64'(ifa.done), 64'(ma.done));
        chk("A.bcd",  64'(ifa.bcd_out), ma.bcd);
        chk("A.neg",  64'(ifa.neg), 64'(ma.neg));
        chk("A.mask", 64'(ifa.digit_mask), ma.mask);
        chk("B.busy", 64'(ifb.busy), 64'(mb.busy));
        chk("B.done", 64'(ifb.done), 64'(mb.done));
        chk("B.bcd",  64'(ifb.bcd_out), mb.bcd);
        chk("B.neg",  64'(ifb.neg), 64'(mb.neg));
        chk("B.mask", 64'(ifb.digit_mask), mb.mask);
    end

    task automatic drive(input int id, input logic st, input logic sg, input logic [63:0] v);
        if (id == 0) begin
            ifa.start = st; ifa.sgn = sg; ifa.bin_in = v[11:0];
        end else begin
            ifb.start = st; ifb.sgn = sg; ifb.bin_in = v[19:0];
        end
    endtask

    // Called at a falling edge with the DUT idle.
    task automatic start_conv(input int id, input logic sg, input logic [63:0] v);
        drive(id, 1'b1, sg, v);
    endtask

    task automatic wait_done(input int id, input bit noise, input int inject_at,
                             input bit chk_hold, input logic [63:0] hold,
                             output int lat, output int busy_cyc);
        logic dn, bz;
        lat = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            dn = (id == 0) ? ifa.done : ifb.done;
            bz = (id == 0) ? ifa.busy : ifb.busy;
            if (dn) begin
                drive(id, 1'b0, 1'b0, 64'($urandom));
                lat = i;
                break;
            end
            if (bz) busy_cyc++;
            if (chk_hold) chk("hold", (id == 0) ? 64'(ifa.bcd_out) : 64'(ifb.bcd_out), hold);
            drive(id, 1'b0, 1'($urandom), 64'($urandom));
            if (i == inject_at) drive(id, 1'b1, 1'b0, 64'd999);
            if (noise && $urandom_range(0, 5) == 0) drive(id, 1'b1, 1'($urandom), 64'($urandom));
        end
        if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic conv_a(input logic sg, input logic [11:0] v, input string tag,
                          input logic [15:0] e_bcd, input logic e_neg, input logic [3:0] e_mask);
        int lat, bc;
        start_conv(0, sg, 64'(v));
        wait_done(0, 1'b0, 0, 1'b0, '0, lat, bc);
        chk({tag, ".lat"},  64'(lat), 64'd13);
        chk({tag, ".bcd"},  64'(ifa.bcd_out), 64'(e_bcd));
        chk({tag, ".neg"},  64'(ifa.neg), 64'(e_neg));
        chk({tag, ".mask"}, 64'(ifa.digit_mask), 64'(e_mask));
    endtask

    initial begin
        int lat, bc, ndone, gap;
        logic [63:0] v;

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("rst.busy", 64'(ifa.busy), 64'd0);
        chk("rst.done", 64'(ifa.done), 64'd0);
        chk("rst.bcd",  64'(ifa.bcd_out), 64'd0);
        chk("rst.neg",  64'(ifa.neg), 64'd0);
        chk("rst.mask", 64'(ifa.digit_mask), 64'd1);
        chk("rstB.mask", 64'(ifb.digit_mask), 64'd1);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Full scale, with busy length and done width.
        start_conv(0, 1'b0, 64'd4095);
        wait_done(0, 1'b0, 0, 1'b0, '0, lat, bc);
        chk("4095.busy_cycles", 64'(bc), 64'd12);
        chk("4095.bcd",  64'(ifa.bcd_out), 64'h4095);
        chk("4095.neg",  64'(ifa.neg), 64'd0);
        chk("4095.mask", 64'(ifa.digit_mask), 64'hF);
        @(negedge clk);
        chk("4095.done_width", 64'(ifa.done), 64'd0);

        conv_a(1'b0, 12'd0,    "zero",   16'h0000, 1'b0, 4'b0001);
        conv_a(1'b0, 12'd907,  "907",    16'h0907, 1'b0, 4'b0111);
        conv_a(1'b1, 12'h800,  "s800",   16'h2048, 1'b1, 4'b1111);
        conv_a(1'b1, 12'hFFF,  "sFFF",   16'h0001, 1'b1, 4'b0001);
        conv_a(1'b1, 12'h7FF,  "s7FF",   16'h2047, 1'b0, 4'b1111);
        conv_a(1'b1, 12'h000,  "szero",  16'h0000, 1'b0, 4'b0001);

        // A start during the conversion must be ignored.
        start_conv(0, 1'b0, 64'd291);
        wait_done(0, 1'b0, 5, 1'b0, '0, lat, bc);
        chk("ignore.lat", 64'(lat), 64'd13);
        chk("ignore.bcd", 64'(ifa.bcd_out), 64'h0291);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start_conv(0, 1'b1, 64'hE00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0);
        repeat (5) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        chk("arst.busy", 64'(ifa.busy), 64'd0);
        chk("arst.done", 64'(ifa.done), 64'd0);
        chk("arst.bcd",  64'(ifa.bcd_out), 64'd0);
        chk("arst.neg",  64'(ifa.neg), 64'd0);
        chk("arst.mask", 64'(ifa.digit_mask), 64'd1);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.done) ndone++;
        end
        chk("arst.no_done", 64'(ndone), 64'd0);
        conv_a(1'b0, 12'd321, "post_rst", 16'h0321, 1'b0, 4'b0111);

        // Back-to-back: new start in the done cycle, old result held meanwhile.
        start_conv(0, 1'b0, 64'd4000);
        wait_done(0, 1'b0, 0, 1'b0, '0, lat, bc);
        chk("b2b.first", 64'(ifa.bcd_out), 64'h4000);
        start_conv(0, 1'b0, 64'd1234);
        wait_done(0, 1'b0, 0, 1'b1, 64'h4000, lat, bc);
        chk("b2b.lat", 64'(lat), 64'd13);
        chk("b2b.bcd", 64'(ifa.bcd_out), 64'h1234);

        // Random conversions with random gaps and stray start pulses.
        for (int n = 0; n < 30; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            start_conv(0, 1'($urandom), 64'($urandom_range(0, 4095)));
            wait_done(0, 1'b1, 0, 1'b0, '0, lat, bc);
            chk("rndA.lat", 64'(lat), 64'd13);
        end

        // Wide instance.
        start_conv(1, 1'b0, 64'd1048575);
        wait_done(1, 1'b0, 0, 1'b0, '0, lat, bc);
        chk("B.max.lat",  64'(lat), 64'd21);
        chk("B.max.bcd",  64'(ifb.bcd_out), 64'h1048575);
        chk("B.max.mask", 64'(ifb.digit_mask), 64'h7F);
        start_conv(1, 1'b1, 64'h80000);
        wait_done(1, 1'b0, 0, 1'b1, 64'h1048575, lat, bc);
        chk("B.min.bcd", 64'(ifb.bcd_out), 64'h524288);
        chk("B.min.neg", 64'(ifb.neg), 64'd1);
        for (int n = 0; n < 10; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            v = 64'($urandom_range(0, 1048575));
            start_conv(1, 1'($urandom), v);
            wait_done(1, 1'b1, 0, 1'b0, '0, lat, bc);
            chk("rndB.lat", 64'(lat), 64'd21);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
